// File: rtl/sim_status_pkg.sv
// Shared types and constants for the simulation status MMIO device.
// Optional signature register is enabled by defining SIM_STATUS_SIG_EN.
package sim_status_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } sim_state_e;

  localparam logic [4:0] TOHOST_OFF  = 5'h00;
  localparam logic [4:0] CYCLE_OFF   = 5'h08;
  localparam logic [4:0] INSTRET_OFF = 5'h10;
  localparam logic [4:0] SIG_OFF     = 5'h18;

  localparam logic [31:0] TIMEOUT_CODE   = 32'hDEAD_0000;
  localparam logic [31:0] MALFORMED_CODE = 32'hFFFF_FFFF;

  // Signature accumulation: rotate left by one, then fold in the new word.
  function automatic logic [63:0] sig_mix(input logic [63:0] sig, input logic [63:0] data);
    return {sig[62:0], sig[63]} ^ data;
  endfunction

endpackage

// File: rtl/sim_watchdog.sv
// Retire-driven watchdog: counts cycles without a kick and flags expiry
// combinationally in the cycle the count sits at LIMIT-1 with no kick.
module sim_watchdog #(
  parameter int unsigned LIMIT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic kick,
  output logic expire
);

  localparam int unsigned CW = $clog2(LIMIT);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count_d;
  logic [CW-1:0] count_q;

  // Next count: kick clears, otherwise count up while enabled and saturate at LAST.
  always_comb begin
    count_d = count_q;
    if (kick) begin
      count_d = '0;
    end else if (enable && (count_q != LAST)) begin
      count_d = count_q + CW'(1'b1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = enable && !kick && (count_q == LAST);

endmodule

// File: rtl/sim_status_mmio.sv
// Memory-mapped simulation status device: tohost verdict, cycle/instret
// counters and watchdog. Define SIM_STATUS_SIG_EN for the signature register.
module sim_status_mmio
  import sim_status_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0000_8000,
  parameter int unsigned WDT_LIMIT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] addr_i,
  input  logic [63:0] wdata_i,
  input  logic        we_i,
  input  logic        re_i,
  output logic [63:0] rdata_o,
  output logic        sel_o,
  input  logic        retire_i,
  output logic        done_o,
  output logic        pass_o,
  output logic [31:0] fail_code_o,
  output logic [1:0]  state_o
);

  logic [63:0] off_s;
  logic [4:0]  reg_off_s;
  logic        run_s;
  logic        wr_tohost_s;
  logic        wdt_expire_s;
  logic [63:0] sig_rd_s;

  sim_state_e  state_d, state_q;
  logic [31:0] fail_code_d, fail_code_q;
  logic        done_d, done_q;
  logic        pass_d, pass_q;
  logic [63:0] cycle_d, cycle_q;
  logic [63:0] instret_d, instret_q;

  // Address decode: window membership, doubleword alignment and strobe.
  always_comb begin
    off_s     = addr_i - BASE_ADDR;
    reg_off_s = off_s[4:0];
    sel_o     = (off_s < 64'd32) && (addr_i[2:0] == 3'b000) && (we_i || re_i);
  end

  assign run_s       = (state_q == ST_RUN);
  assign wr_tohost_s = sel_o && we_i && (reg_off_s == TOHOST_OFF);

  sim_watchdog #(
    .LIMIT (WDT_LIMIT)
  ) u_wdt (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (run_s),
    .kick   (retire_i),
    .expire (wdt_expire_s)
  );

  // Verdict FSM next state; a tohost write takes priority over watchdog expiry.
  always_comb begin
    state_d     = state_q;
    fail_code_d = fail_code_q;
    case (state_q)
      ST_RUN: begin
        if (wr_tohost_s && (wdata_i != 64'd0)) begin
          if (wdata_i == 64'd1) begin
            state_d = ST_PASS;
          end else if (wdata_i[0]) begin
            state_d     = ST_FAIL;
            fail_code_d = wdata_i[32:1];
          end else begin
            state_d     = ST_FAIL;
            fail_code_d = MALFORMED_CODE;
          end
        end else if (wdt_expire_s) begin
          state_d     = ST_TIMEOUT;
          fail_code_d = TIMEOUT_CODE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d     = state_q;
        fail_code_d = fail_code_q;
      end
    endcase
    done_d = (state_d != ST_RUN);
    pass_d = (state_d == ST_PASS);
  end

  // Counters run only while the program is still running.
  always_comb begin
    cycle_d   = cycle_q;
    instret_d = instret_q;
    if (run_s) begin
      cycle_d = cycle_q + 64'd1;
      if (retire_i) begin
        instret_d = instret_q + 64'd1;
      end else begin
        instret_d = instret_q;
      end
    end else begin
      cycle_d   = cycle_q;
      instret_d = instret_q;
    end
  end

  // State, verdict and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      fail_code_q <= 32'd0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      cycle_q     <= 64'd0;
      instret_q   <= 64'd0;
    end else begin
      state_q     <= state_d;
      fail_code_q <= fail_code_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      cycle_q     <= cycle_d;
      instret_q   <= instret_d;
    end
  end

`ifdef SIM_STATUS_SIG_EN
  logic [63:0] sig_d, sig_q;

  // Signature update on writes in RUN; frozen once a verdict is reached.
  always_comb begin
    sig_d = sig_q;
    if (run_s && sel_o && we_i && (reg_off_s == SIG_OFF)) begin
      sig_d = sig_mix(sig_q, wdata_i);
    end else begin
      sig_d = sig_q;
    end
  end

  // Signature register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 64'd0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_rd_s = sig_q;
`else
  assign sig_rd_s = 64'd0;
`endif

  // Zero-latency read mux; tohost and unselected accesses read as zero.
  always_comb begin
    rdata_o = 64'd0;
    if (sel_o) begin
      case (reg_off_s)
        CYCLE_OFF:   rdata_o = cycle_q;
        INSTRET_OFF: rdata_o = instret_q;
        SIG_OFF:     rdata_o = sig_rd_s;
        default:     rdata_o = 64'd0;
      endcase
    end else begin
      rdata_o = 64'd0;
    end
  end

  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign fail_code_o = fail_code_q;
  assign state_o     = state_q;

endmodule
